// File: rtl/discrete_meter_pkg.sv
// Shared types and helpers for the audio period meter.
// Provides the FSM state type, sample width and threshold helpers.
package discrete_meter_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic {
    IDLE,
    MEASURE
  } meter_state_t;

  // Hysteresis threshold, widened to 17 bit signed so that the
  // full-scale samples compare without overflow.
  function automatic logic signed [SAMPLE_W:0] thr(
    input int  h,
    input logic neg
  );
    logic signed [SAMPLE_W:0] t;
    t = $signed({1'b0, h[SAMPLE_W-1:0]});
    return neg ? -t : t;
  endfunction

  function automatic logic signed [SAMPLE_W:0] sext(
    input logic signed [SAMPLE_W-1:0] s
  );
    return $signed({s[SAMPLE_W-1], s});
  endfunction

endpackage

// File: rtl/audio_period_meter_schmitt_trigger.sv
// Hysteresis comparator: en, in -> level (registered), rise/fall
// (combinational pulses on the sample that flips level).
module schmitt_trigger
  import discrete_meter_pkg::*;
#(
  parameter int HYST = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] in,
  output logic                       level,
  output logic                       rise,
  output logic                       fall
);

  logic level_q;
  logic level_d;
  logic signed [SAMPLE_W:0] in_x;

  always_comb begin
    in_x    = sext(in);
    rise    = en && !level_q && (in_x > thr(HYST, 1'b0));
    fall    = en && level_q && (in_x < thr(HYST, 1'b1));
    level_d = level_q;
    if (rise) level_d = 1'b1;
    else if (fall) level_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_q <= 1'b0;
    else          level_q <= level_d;
  end

  assign level = level_q;

endmodule

// File: rtl/audio_period_meter.sv
// Measures period and high time of a signed audio stream in samples.
// Ports: clk, reset_n, audio_clk_en, in -> period, high_time, valid, timeout, level.
module audio_period_meter
  import discrete_meter_pkg::*;
#(
  parameter int MAX_PERIOD = 65535,
  parameter int HYST       = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       audio_clk_en,
  input  logic signed [SAMPLE_W-1:0] in,
  output logic [15:0]                period,
  output logic [15:0]                high_time,
  output logic                       valid,
  output logic                       timeout,
  output logic                       level
);

  localparam logic [15:0] MAX_P = MAX_PERIOD[15:0];

  logic         rise;
  logic         fall;

  meter_state_t state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [15:0]  hi_lat_q, hi_lat_d;
  logic         fell_q, fell_d;
  logic [15:0]  period_q, period_d;
  logic [15:0]  high_q, high_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;

  schmitt_trigger #(
    .HYST (HYST)
  ) u_schmitt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (audio_clk_en),
    .in      (in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_lat_d  = hi_lat_q;
    fell_d    = fell_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (audio_clk_en) begin
      if (rise)                cnt_d = 16'd1;
      else if (cnt_q != MAX_P) cnt_d = cnt_q + 16'd1;
      // fell_q tracks whether hi_lat belongs to the current cycle
      if (fall) begin
        hi_lat_d = cnt_q;
        fell_d   = 1'b1;
      end
      if (rise) fell_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) state_d = MEASURE;
        end
        MEASURE: begin
          // an edge on the saturating sample beats the timeout
          if (rise) begin
            period_d  = cnt_q;
            high_d    = fell_q ? hi_lat_q : cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
          end else if (cnt_q == MAX_P) begin
            period_d  = 16'd0;
            high_d    = 16'd0;
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      hi_lat_q  <= 16'd0;
      fell_q    <= 1'b0;
      period_q  <= 16'd0;
      high_q    <= 16'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_lat_q  <= hi_lat_d;
      fell_q    <= fell_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_audio_period_meter.sv
// Directed bench for audio_period_meter.
// Two instances: MAX_PERIOD=100 (main) and MAX_PERIOD=30 (edge at saturation).
module tb_audio_period_meter;

  logic clk = 1'b0;
  logic reset_n;
  logic en_a, en_b;
  logic signed [15:0] in_a, in_b;
  logic [15:0] per_a, hi_a, per_b, hi_b;
  logic val_a, to_a, lv_a, val_b, to_b, lv_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  audio_period_meter #(
    .MAX_PERIOD (100),
    .HYST       (1024)
  ) dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .audio_clk_en (en_a),
    .in           (in_a),
    .period       (per_a),
    .high_time    (hi_a),
    .valid        (val_a),
    .timeout      (to_a),
    .level        (lv_a)
  );

  audio_period_meter #(
    .MAX_PERIOD (30),
    .HYST       (1024)
  ) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .audio_clk_en (en_b),
    .in           (in_b),
    .period       (per_b),
    .high_time    (hi_b),
    .valid        (val_b),
    .timeout      (to_b),
    .level        (lv_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic signed [15:0] v);
    in_a = v;
    en_a = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic stepb(input logic signed [15:0] v);
    in_b = v;
    en_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // 10 high then 10 low samples; the first high sample is a rising edge
  task automatic cycle(input logic exp_valid, input logic glitch);
    step(16'sd8000);
    chk("cyc_valid", {31'd0, val_a}, {31'd0, exp_valid});
    if (exp_valid) begin
      chk("cyc_period", {16'd0, per_a}, 32'd20);
      chk("cyc_high", {16'd0, hi_a}, 32'd10);
    end
    for (int i = 1; i < 10; i++) begin
      step((glitch && i == 5) ? -16'sd600 : 16'sd8000);
      if (glitch && i == 5) chk("glitch_hi_lvl", {31'd0, lv_a}, 32'd1);
    end
    chk("cyc_lvl_hi", {31'd0, lv_a}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step((glitch && i == 5) ? 16'sd600 : -16'sd8000);
      if (glitch && i == 5) chk("glitch_lo_lvl", {31'd0, lv_a}, 32'd0);
    end
    chk("cyc_lvl_lo", {31'd0, lv_a}, 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, {16'd0, per_a}, 32'd0);
    chk({tag, "_high"}, {16'd0, hi_a}, 32'd0);
    chk({tag, "_valid"}, {31'd0, val_a}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, to_a}, 32'd0);
    chk({tag, "_level"}, {31'd0, lv_a}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    in_a = 16'sd0;
    in_b = 16'sd0;
    #2;
    chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // square wave, first valid on second rising edge
    for (int i = 0; i < 10; i++) step(-16'sd8000);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    chk("sq_timeout", {31'd0, to_a}, 32'd0);

    // glitches inside the band change nothing
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);

    // timeout: constant in-band input after a rising edge
    step(16'sd8000);
    chk("to_pre_valid", {31'd0, val_a}, 32'd1);
    for (int k = 1; k < 100; k++) step(16'sd500);
    chk("to_not_yet", {31'd0, to_a}, 32'd0);
    step(16'sd500);
    chk("to_set", {31'd0, to_a}, 32'd1);
    chk("to_period", {16'd0, per_a}, 32'd0);
    chk("to_high", {16'd0, hi_a}, 32'd0);
    chk("to_valid", {31'd0, val_a}, 32'd0);
    step(16'sd500);
    chk("to_hold", {31'd0, to_a}, 32'd1);

    // resume: timeout clears on the second edge
    for (int i = 0; i < 10; i++) step(-16'sd8000);
    cycle(1'b0, 1'b0);
    chk("resume_to_still", {31'd0, to_a}, 32'd1);
    cycle(1'b1, 1'b0);
    chk("resume_to_clr", {31'd0, to_a}, 32'd0);

    // strobe gated off mid-period while the input swings
    step(16'sd8000);
    chk("gate_valid", {31'd0, val_a}, 32'd1);
    for (int i = 0; i < 4; i++) step(16'sd8000);
    en_a = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_a = i[0] ? -16'sd8000 : 16'sd8000;
      @(posedge clk);
      #1;
    end
    chk("gate_level", {31'd0, lv_a}, 32'd1);
    chk("gate_novalid", {31'd0, val_a}, 32'd0);
    for (int i = 0; i < 5; i++) step(16'sd8000);
    for (int i = 0; i < 10; i++) step(-16'sd8000);
    step(16'sd8000);
    chk("gate_valid2", {31'd0, val_a}, 32'd1);
    chk("gate_period", {16'd0, per_a}, 32'd20);
    chk("gate_high", {16'd0, hi_a}, 32'd10);

    // asynchronous reset between edges
    step(16'sd8000);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("areset");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step(-16'sd8000);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    en_a = 1'b0;

    // MAX_PERIOD=30, edges land on cnt==30; full-scale samples
    for (int i = 0; i < 15; i++) stepb(-16'sd32768);
    for (int c = 0; c < 3; c++) begin
      stepb(16'sd32767);
      if (c > 0) begin
        chk("sat_valid", {31'd0, val_b}, 32'd1);
        chk("sat_period", {16'd0, per_b}, 32'd30);
        chk("sat_high", {16'd0, hi_b}, 32'd15);
        chk("sat_timeout", {31'd0, to_b}, 32'd0);
      end
      for (int i = 1; i < 15; i++) stepb(16'sd32767);
      chk("sat_lvl_hi", {31'd0, lv_b}, 32'd1);
      for (int i = 0; i < 15; i++) stepb(-16'sd32768);
      chk("sat_lvl_lo", {31'd0, lv_b}, 32'd0);
    end
    stepb(16'sd32767);
    chk("sat_last_to", {31'd0, to_b}, 32'd0);
    stepb(16'sd32767);
    chk("sat_pulse_end", {31'd0, val_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_period_meter.md
# audio_period_meter

Measures the fundamental period and high time of a signed 16-bit audio stream, one sample per `audio_clk_en` strobe. It sits on the output side of the discrete oscillator models (555 VCO and similar) and turns a waveform back into a period figure. Uses: closed-loop checks of `v_control`→frequency mappings in simulation, and on-chip pitch readback for debug. Edge detection uses a hysteresis comparator. A missing oscillation is reported as a timeout and never leaves a stale period.

## Interface
- `MAX_PERIOD`, 65535: saturation and timeout limit, in samples. Range 2..65535.
- `HYST`, 1024: hysteresis half-width. Thresholds are +HYST (rising) and −HYST (falling). Range 0..16383.
- `clk`, input, 1: system clock. Single clock domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `audio_clk_en`, input, 1: sample strobe. Input is consumed only on cycles where it is high.
- `in`, input, signed 16: audio sample.
- `period`, output, 16: samples between the last two rising edges.
- `high_time`, output, 16: samples from a rising edge to the following falling edge, for the same cycle as `period`.
- `valid`, output, 1: one-`clk` pulse when `period`/`high_time` update.
- `timeout`, output, 1: level. No rising edge seen within MAX_PERIOD samples.
- `level`, output, 1: current comparator state (1 = high).

## Operation
- Comparator, evaluated only on `audio_clk_en`:
  - `level` 0 → 1 when `in > HYST` (signed compare). This is a rising edge.
  - `level` 1 → 0 when `in < -HYST`. This is a falling edge.
  - Values inside the band never toggle `level`.
- Sample counter `cnt` (16 bit):
  - On a rising edge: `cnt <= 1`.
  - Otherwise: `cnt <= cnt + 1`, saturating at MAX_PERIOD.
- Falling edge: `hi_lat <= cnt`.
- FSM states: IDLE, MEASURE.
- IDLE:
  - Reset state, also entered after a timeout.
  - On a rising edge → MEASURE. Start `cnt`. `valid` stays low, because the first edge has no reference.
- MEASURE, on a rising edge:
  - `period <= cnt`.
  - `high_time <= hi_lat`, or `cnt` if no falling edge occurred in this cycle.
  - `valid` pulses.
  - `timeout <= 0`.
  - Stay in MEASURE.
- MEASURE, timeout:
  - Condition: `cnt == MAX_PERIOD` on a strobe with no rising edge.
  - `timeout <= 1`, `period <= 0`, `high_time <= 0`, no `valid`.
  - → IDLE.
- Simultaneous edge and saturation: the edge wins. `period = MAX_PERIOD`, `valid` pulses, no timeout.
- Negative full scale (−32768) and positive full scale (32767) follow the same compare rules. No overflow is possible: thresholds are computed in 17 bit signed.
- `in` is ignored while `audio_clk_en` is low. All state holds.

## Timing
- Reset values (asynchronous, immediate):
  - `period = 0`, `high_time = 0`, `valid = 0`, `timeout = 0`, `level = 0`.
  - FSM = IDLE, `cnt = 0`, `hi_lat = 0`.
- Latency:
  - Outputs register on the `clk` edge that samples `audio_clk_en` = 1 together with the edge sample.
  - `valid` is high for exactly the following `clk` cycle, then returns low, even if `audio_clk_en` is held high.
- `period` and `high_time` hold between updates. Downstream may sample them at any time.
- Back-to-back strobes on consecutive clocks are legal. A period of 2 samples is the minimum measurable.
- Reset deasserted mid-waveform: a fresh IDLE wait. The first `valid` arrives at the second rising edge after reset.

## Structure
- Package `discrete_meter_pkg` holds:
  - `meter_state_t` enum (IDLE, MEASURE).
  - `SAMPLE_W = 16`.
  - Shared threshold helper function.
- Sub-module `schmitt_trigger`:
  - Parameter: HYST.
  - Ports: `clk`, `reset_n`, `en`, `in` → `level`, `rise`, `fall` (rise/fall are single-strobe pulses).
  - The top level holds the counter, latches and FSM.

## Test plan
- Square wave ±8000, 10 samples high, 10 low, HYST = 1024:
  - First `valid` at the 2nd rising edge.
  - Thereafter `period = 20`, `high_time = 10`, `valid` every 20 strobes.
  - `timeout = 0`.
- Same wave with a ±600 glitch inserted mid-high and mid-low:
  - Outputs unchanged (20/10).
  - `level` never toggles on the glitch.
- Constant `in = 500`, MAX_PERIOD = 100, after one valid period:
  - `timeout` rises exactly 100 strobes after the last rising edge.
  - `period = 0`, `high_time = 0`, no `valid`.
  - Resuming the square wave: `timeout` clears on the next `valid` (second edge after resume).
- Rising edge landing exactly on `cnt == MAX_PERIOD` (MAX_PERIOD = 30, period-30 wave):
  - `valid` with `period = 30`.
  - `timeout` stays 0.
- Assert `reset_n = 0` between edges for 3 clocks:
  - All outputs 0 immediately, without waiting for `clk`.
  - After release, two rising edges are required before `valid`.
- Hold `audio_clk_en = 0` for 50 clocks mid-period while `in` swings ±8000:
  - `cnt`, `level` and the outputs are frozen.
  - The measured period counts strobes only.
